bus_arbiter8: RTL



---
 rtl/bus_arb_pkg.sv | 24 ++
 rtl/bus_arbiter8_rr_pick.sv | 33 +++
 rtl/bus_arbiter8.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus arbiter.
// State encoding, default requester count and width helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int NREQ_DEF = 4;

  // Ceiling log2, never less than 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_arbiter8_rr_pick.sv
// Combinational round-robin picker.
// First set req bit searching upward from ptr, wrapping.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] ptr,
  output logic [clog2(NREQ)-1:0] idx,
  output logic                   valid
);

  localparam int W = clog2(NREQ);

  logic [W:0] sum;

  // Walk candidates ptr, ptr+1, ... modulo NREQ; keep the first hit.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (W+1)'(i);
      if (sum >= (W+1)'(NREQ)) sum = sum - (W+1)'(NREQ);
      if (!valid && req[sum[W-1:0]]) begin
        valid = 1'b1;
        idx   = sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin tristate bus arbiter with dead-cycle sequencing.
// Optional hold timeout: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter8
  import bus_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        read_en,
  output logic [clog2(NREQ)-1:0] owner,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int W = clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 1) begin : g_bad_param
    $error("bus_arbiter8: NREQ must be 2..8, MAX_HOLD >= 1");
  end

  arb_state_t      state, state_n;
  logic [W-1:0]    ptr, ptr_n, owner_n;
  logic [W-1:0]    pick_idx;
  logic            pick_valid;
  logic [NREQ-1:0] gnt_n, read_en_n;
  logic            busy_n;
  logic            tmo;
  logic            rel_norm;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign rel_norm = done[owner] || !req[owner];

  // State and registered outputs; reset wins in any state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      gnt     <= '0;
      read_en <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      gnt     <= gnt_n;
      read_en <= read_en_n;
      busy    <= busy_n;
    end
  end

  // Next state plus next output values, so every output is a flop.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    gnt_n     = '0;
    read_en_n = '0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_n = pick_idx;
          state_n = GRANT;
          gnt_n   = ONE << pick_idx;
        end
      end
      GRANT: begin
        state_n   = ACTIVE;
        gnt_n     = ONE << owner;
        read_en_n = ONE << owner;
      end
      ACTIVE: begin
        if (rel_norm || tmo) begin
          state_n = RELEASE;
          ptr_n   = (owner == W'(NREQ-1)) ? '0 : owner + 1'b1;
        end else begin
          gnt_n     = ONE << owner;
          read_en_n = ONE << owner;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == GRANT) || (state_n == ACTIVE);
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = clog2(MAX_HOLD);

  logic [HW-1:0] hold_cnt;

  assign tmo = (state == ACTIVE) && (hold_cnt == HW'(MAX_HOLD-1));

  // Count ACTIVE cycles; flag a forced release not covered by done/req drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo && !rel_norm;
      if (state == GRANT) hold_cnt <= '0;
      else if (state == ACTIVE) hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
